fetch_queue: RTL

Parametrised instruction-fetch front end for the MIPS processor. It owns the program counter and drives a synchronous-read instruction ROM. Fetched instructions are buffered in a prefetch FIFO, and each one is handed to decode with a valid/ready handshake. Branch, jump and register-jump redirects flush the queue, with optional MIPS branch-delay-slot semantics. It replaces the single-register PC update of the single-cycle core and allows decode to stall without losing fetch bandwidth.

---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch front end. Owns the fetch PC, drives a
//             synchronous-read instruction ROM, buffers responses in a
//             shift-register prefetch FIFO and hands the head instruction to
//             decode over a valid/ready handshake. Redirects flush the queue.
//  Options  : FETCH_DELAY_SLOT_EN - keep one sequential instruction (the MIPS
//             branch-delay slot) across a redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 'h0040_0000,
   parameter int                DEPTH    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic [ADDR_W-1:0]       imem_addr_out,
   output logic                    imem_req_out,
   input  logic [31:0]             imem_data_in,
   input  logic                    redirect_in,
   input  logic [ADDR_W-1:0]       redirect_pc_in,
   output logic [31:0]             inst_out,
   output logic [ADDR_W-1:0]       inst_pc_out,
   output logic [ADDR_W-1:0]       inst_pcn_out,
   output logic                    inst_valid_out,
   input  logic                    inst_ready_in,
   output logic [$clog2(DEPTH):0]  count_out
);

   localparam int              CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

   // Entry 0 is always the head, so the outputs are plain register reads.
   logic [31:0]       inst_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] req_pc;    // address of the request now in flight
   logic              inflight;

   logic              pop;
   logic              issue;
   logic              flush;     // redirect that actually acts on the queue
   logic [CNT_W:0]    occupancy;
   logic [CNT_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] target;

`ifdef FETCH_DELAY_SLOT_EN
   logic              pend;
   logic [ADDR_W-1:0] pend_pc;
   // While the slot fetch is still owed, a new redirect only retargets it.
   assign flush = redirect_in && !pend;
`else
   assign flush = redirect_in;
`endif

   assign target    = redirect_pc_in & ~ADDR_W'(3);
   assign pop       = (count != '0) && inst_ready_in;
   assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign issue     = !reset && !flush && (occupancy < DEPTH_C);
   assign wr_idx    = count - CNT_W'(pop);

   assign imem_req_out   = issue;
   assign imem_addr_out  = fpc;
   assign inst_out       = inst_q[0];
   assign inst_pc_out    = pc_q[0];
   assign inst_pcn_out   = pc_q[0] + ADDR_W'(4);
   assign inst_valid_out = (count != '0);
   assign count_out      = count;

   // Fetch PC, in-flight tracking and FIFO update (reset > redirect > push/pop).
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
         count    <= '0;
         inflight <= 1'b0;
         fpc      <= RESET_PC;
         req_pc   <= RESET_PC;
`ifdef FETCH_DELAY_SLOT_EN
         pend     <= 1'b0;
         pend_pc  <= '0;
`endif
      end else if (flush) begin
         // No request goes out in a redirect cycle, so nothing stays in flight.
         inflight <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
         if (count >= CNT_W'(2)) begin
            // Entry 1 follows the branch (popped or at the head): it is the slot.
            inst_q[0] <= inst_q[1];
            pc_q[0]   <= pc_q[1];
            count     <= CNT_W'(1);
            fpc       <= target;
         end else if (inflight) begin
            // The arriving response is the instruction after the branch.
            inst_q[0] <= imem_data_in;
            pc_q[0]   <= req_pc;
            count     <= CNT_W'(1);
            fpc       <= target;
         end else begin
            // Slot not fetched yet: fetch it from fpc first, then go to target.
            count   <= '0;
            pend    <= 1'b1;
            pend_pc <= target;
         end
`else
         count <= '0;
         fpc   <= target;
`endif
      end else begin
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               inst_q[i] <= inst_q[i+1];
               pc_q[i]   <= pc_q[i+1];
            end
         end
         if (inflight) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wr_idx == CNT_W'(i)) begin
                  inst_q[i] <= imem_data_in;
                  pc_q[i]   <= req_pc;
               end
            end
         end
         count    <= count + CNT_W'(inflight) - CNT_W'(pop);
         inflight <= issue;
         if (issue) begin
            req_pc <= fpc;
`ifdef FETCH_DELAY_SLOT_EN
            if (pend) begin
               fpc  <= redirect_in ? target : pend_pc;
               pend <= 1'b0;
            end else begin
               fpc <= fpc + ADDR_W'(4);
            end
`else
            fpc <= fpc + ADDR_W'(4);
`endif
         end
`ifdef FETCH_DELAY_SLOT_EN
         else if (redirect_in) begin
            pend_pc <= target;
         end
`endif
      end
   end

endmodule
`default_nettype wire
